// File: rtl/perspective_pkg.sv
// Shared widths, coefficient packing and FSM encoding for the keystone
// perspective-parameter sequencer.
package perspective_pkg;

  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int CORNERS = 4;
  localparam int CX_W    = X_W * CORNERS;
  localparam int CY_W    = Y_W * CORNERS;

  localparam int P1_W = 36;
  localparam int P2_W = 36;
  localparam int P3_W = 44;
  localparam int P4_W = 35;
  localparam int P5_W = 35;
  localparam int P6_W = 43;
  localparam int P7_W = 24;
  localparam int P8_W = 24;
  localparam int P9_W = 33;

  // Coefficients are packed LSB-first, p1 at bit 0.
  localparam int P1_OFF = 0;
  localparam int P2_OFF = P1_OFF + P1_W;
  localparam int P3_OFF = P2_OFF + P2_W;
  localparam int P4_OFF = P3_OFF + P3_W;
  localparam int P5_OFF = P4_OFF + P4_W;
  localparam int P6_OFF = P5_OFF + P5_W;
  localparam int P7_OFF = P6_OFF + P6_W;
  localparam int P8_OFF = P7_OFF + P7_W;
  localparam int P9_OFF = P8_OFF + P8_W;
  localparam int PARAMS_W = P9_OFF + P9_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } seq_state_t;

  // A zero projective denominator means the quad collapsed to a line or point.
  function automatic logic p9_is_zero(input logic [PARAMS_W-1:0] p);
    return p[P9_OFF +: P9_W] == '0;
  endfunction

endpackage

// File: rtl/param_double_buffer.sv
// Shadow/active coefficient banks: capture writes the shadow, a frame boundary
// publishes it to the active bank.
module param_double_buffer
  import perspective_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [PARAMS_W-1:0] wr_data,
  input  logic                swap_req,
  output logic [PARAMS_W-1:0] params,
  output logic                params_valid
);

  logic [PARAMS_W-1:0] shadow;
  logic                pending;

  // A write in the same cycle as a frame boundary wins; the fresh set waits
  // for the next boundary rather than tearing the current frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow       <= '0;
      params       <= '0;
      params_valid <= 1'b0;
      pending      <= 1'b0;
    end else if (wr_en) begin
      shadow  <= wr_data;
      pending <= 1'b1;
    end else if (swap_req && pending) begin
      params       <= shadow;
      params_valid <= 1'b1;
      pending      <= 1'b0;
    end
  end

endmodule

// File: rtl/perspective_params_sequencer.sv
// Drives the perspective_params datapath with a corner quad, waits out its
// latency and hands non-degenerate coefficient sets to the double buffer.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no computation; accepts a live strobe or a held request
// LOAD    | present held corner copy on dp_x/dp_y, arm latency counter
// WAIT    | datapath inputs frozen, counter runs down to zero
// CAPTURE | sample dp_params; publish to shadow or flag degenerate
module perspective_params_sequencer
  import perspective_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                corners_valid,
  input  logic [CX_W-1:0]     corner_x,
  input  logic [CY_W-1:0]     corner_y,
  input  logic                frame_start,
  output logic [CX_W-1:0]     dp_x,
  output logic [CY_W-1:0]     dp_y,
  input  logic [PARAMS_W-1:0] dp_params,
  output logic [PARAMS_W-1:0] params,
  output logic                params_valid,
  output logic                busy,
  output logic                degenerate
);

  seq_state_t       state;
  seq_state_t       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CX_W-1:0]  hold_x;
  logic [CY_W-1:0]  hold_y;
  logic             req_held;
  logic             capture_ok;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:    if (corners_valid || req_held) state_nx = ST_LOAD;
      ST_LOAD:    state_nx = ST_WAIT;
      ST_WAIT:    if (cnt == '0) state_nx = ST_CAPTURE;
      ST_CAPTURE: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // The hold register doubles as the launch register: in IDLE a live strobe
  // lands here and LOAD copies it out, so both paths share one route to dp_x.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_x     <= '0;
      hold_y     <= '0;
      req_held   <= 1'b0;
      dp_x       <= '0;
      dp_y       <= '0;
      cnt        <= '0;
      degenerate <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        if (corners_valid) begin
          hold_x <= corner_x;
          hold_y <= corner_y;
        end
        req_held <= 1'b0;
      end else if (corners_valid) begin
        hold_x   <= corner_x;
        hold_y   <= corner_y;
        req_held <= 1'b1;
      end

      if (state == ST_LOAD) begin
        dp_x <= hold_x;
        dp_y <= hold_y;
        cnt  <= CNT_W'(LATENCY - 1);
      end

      if (state == ST_WAIT && cnt != '0) cnt <= cnt - CNT_W'(1);

      degenerate <= (state == ST_CAPTURE) && p9_is_zero(dp_params);
    end
  end

  assign capture_ok = (state == ST_CAPTURE) && !p9_is_zero(dp_params);
  assign busy       = (state != ST_IDLE);

  param_double_buffer u_bank (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (capture_ok),
    .wr_data      (dp_params),
    .swap_req     (frame_start),
    .params       (params),
    .params_valid (params_valid)
  );

endmodule

// File: tb/tb_perspective_params_sequencer.sv
// Bench for perspective_params_sequencer: stub datapath with real latency, a
// transaction-timed reference model, directed scenarios and random traffic.
module tb_perspective_params_sequencer;
  import perspective_pkg::*;

  localparam int LAT = 4;

  logic                clock = 1'b0;
  logic                reset;
  logic                corners_valid;
  logic [CX_W-1:0]     corner_x;
  logic [CY_W-1:0]     corner_y;
  logic                frame_start;
  logic [CX_W-1:0]     dp_x;
  logic [CY_W-1:0]     dp_y;
  logic [PARAMS_W-1:0] dp_params;
  logic [PARAMS_W-1:0] params;
  logic                params_valid;
  logic                busy;
  logic                degenerate;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  perspective_params_sequencer #(.LATENCY(LAT), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .corners_valid(corners_valid),
    .corner_x(corner_x), .corner_y(corner_y), .frame_start(frame_start),
    .dp_x(dp_x), .dp_y(dp_y), .dp_params(dp_params), .params(params),
    .params_valid(params_valid), .busy(busy), .degenerate(degenerate)
  );

  // Nominal quad and the coefficients the real datapath gives for it.
  localparam logic [CX_W-1:0] NOM_X = {10'd296, 10'd57, 10'd163, 10'd382};
  localparam logic [CY_W-1:0] NOM_Y = {9'd127, 9'd335, 9'd401, 9'd380};
  longint nom_v [9] = '{-64'sd43623150, 64'sd13416748, 64'sd27740167680,
                        -64'sd36762000, 64'sd68191980, 64'sd27594931200,
                        -64'sd63426, 64'sd162132, 64'sd72618240};
  int fw [9] = '{P1_W, P2_W, P3_W, P4_W, P5_W, P6_W, P7_W, P8_W, P9_W};
  int fo [9] = '{P1_OFF, P2_OFF, P3_OFF, P4_OFF, P5_OFF, P6_OFF, P7_OFF, P8_OFF, P9_OFF};

  function automatic logic [PARAMS_W-1:0] nom_params();
    logic [PARAMS_W-1:0] r = '0;
    for (int k = 0; k < 9; k++)
      for (int b = 0; b < fw[k]; b++) r[fo[k]+b] = nom_v[k][b];
    return r;
  endfunction

  function automatic longint get_field(input logic [PARAMS_W-1:0] p, input int k);
    longint r = 0;
    for (int i = 0; i < 64; i++) r[i] = (i < fw[k]) ? p[fo[k]+i] : p[fo[k]+fw[k]-1];
    return r;
  endfunction

  // Stub datapath transfer function; x1 == 0 models a collapsed quad (p9 = 0).
  function automatic logic [PARAMS_W-1:0] dp_func(input logic [CX_W-1:0] x, input logic [CY_W-1:0] y);
    logic [379:0] t;
    logic [PARAMS_W-1:0] r;
    if (x === NOM_X && y === NOM_Y) return nom_params();
    t = {5{x, y}};
    r = t[PARAMS_W-1:0] ^ {10{31'h5A5A1234}};
    if (x[9:0] == '0) r[P9_OFF +: P9_W] = '0;
    else r[P9_OFF] = 1'b1;
    return r;
  endfunction

  logic [CX_W-1:0] px [LAT];
  logic [CY_W-1:0] py [LAT];
  always @(posedge clock) begin
    px[0] <= dp_x;
    py[0] <= dp_y;
    for (int i = 1; i < LAT; i++) begin
      px[i] <= px[i-1];
      py[i] <= py[i-1];
    end
  end
  assign dp_params = dp_func(px[LAT-1], py[LAT-1]);

  // Reference model: a job started at edge s drives dp at s+1 and resolves at
  // s+LAT+2; a strobe while a job is open overwrites a single held slot.
  bit                  m_ready = 0;
  longint              ecyc = 0;
  bit                  job_act, held_v, e_pending, e_pvalid, e_busy, e_degen;
  longint              job_s;
  logic [CX_W-1:0]     job_x, held_x, e_dpx;
  logic [CY_W-1:0]     job_y, held_y, e_dpy;
  logic [PARAMS_W-1:0] e_shadow, e_params, res;

  initial begin : model
    bit idle_before, wr;
    forever begin
      @(posedge clock);
      ecyc++;
      if (reset) begin
        m_ready = 1; job_act = 0; held_v = 0; e_pending = 0; e_pvalid = 0;
        e_busy = 0; e_degen = 0; e_dpx = '0; e_dpy = '0;
        e_shadow = '0; e_params = '0;
      end else if (m_ready) begin
        idle_before = !job_act;
        wr = 0;
        e_degen = 0;
        if (job_act && ecyc == job_s + 1) begin e_dpx = job_x; e_dpy = job_y; end
        if (job_act && ecyc == job_s + LAT + 2) begin
          job_act = 0;
          res = dp_func(job_x, job_y);
          if (res[P9_OFF +: P9_W] == '0) e_degen = 1;
          else wr = 1;
        end
        if (wr) begin
          e_shadow = res; e_pending = 1;
        end else if (frame_start && e_pending) begin
          e_params = e_shadow; e_pvalid = 1; e_pending = 0;
        end
        if (idle_before) begin
          if (corners_valid) begin
            job_act = 1; job_s = ecyc; job_x = corner_x; job_y = corner_y;
          end else if (held_v) begin
            job_act = 1; job_s = ecyc; job_x = held_x; job_y = held_y;
          end
          held_v = 0;
        end else if (corners_valid) begin
          held_x = corner_x; held_y = corner_y; held_v = 1;
        end
        e_busy = job_act;
      end
    end
  end

  task automatic chk(input string nm, input logic [PARAMS_W-1:0] act, input logic [PARAMS_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (m_ready) begin
      chk("busy", PARAMS_W'(busy), PARAMS_W'(e_busy));
      chk("dp_x", PARAMS_W'(dp_x), PARAMS_W'(e_dpx));
      chk("dp_y", PARAMS_W'(dp_y), PARAMS_W'(e_dpy));
      chk("params", params, e_params);
      chk("params_valid", PARAMS_W'(params_valid), PARAMS_W'(e_pvalid));
      chk("degenerate", PARAMS_W'(degenerate), PARAMS_W'(e_degen));
    end
  end

  logic [CX_W-1:0] quad_b;
  bit watch_b = 0, saw_b = 0;
  always @(negedge clock) if (watch_b && dp_x === quad_b) saw_b = 1;

  task automatic drive(input bit cv, input logic [CX_W-1:0] x, input logic [CY_W-1:0] y,
                       input bit fs, input bit rs);
    corners_valid = cv; corner_x = x; corner_y = y; frame_start = fs; reset = rs;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, '0, '0, 0, 0);
  endtask

  function automatic logic [CX_W-1:0] rq_x(input logic [9:0] tag);
    logic [CX_W-1:0] x = {$urandom, $urandom};
    x[39:30] = tag;
    if (x[9:0] == '0) x[0] = 1'b1;
    return x;
  endfunction

  initial begin : stim
    logic [CX_W-1:0] xa, xc, xd, xe, xf, xg, xdeg;
    logic [CY_W-1:0] ya, yc, yd, ye, yf, yg;
    logic [PARAMS_W-1:0] snap;
    corners_valid = 0; corner_x = '0; corner_y = '0; frame_start = 0; reset = 1;
    @(negedge clock);
    drive(0, '0, '0, 0, 1);
    drive(0, '0, '0, 0, 1);

    chk("rst_busy", PARAMS_W'(busy), '0);
    chk("rst_params", params, '0);
    chk("rst_params_valid", PARAMS_W'(params_valid), '0);
    chk("rst_dp_x", PARAMS_W'(dp_x), '0);

    // nominal quad
    drive(1, NOM_X, NOM_Y, 0, 0);
    idle(LAT + 2);
    chk("nom_before_swap", params, '0);
    chk("nom_dp_x", PARAMS_W'(dp_x), PARAMS_W'(NOM_X));
    drive(0, '0, '0, 1, 0);
    for (int k = 0; k < 9; k++)
      chk($sformatf("nom_p%0d", k + 1), PARAMS_W'(get_field(params, k)), PARAMS_W'(nom_v[k]));
    chk("nom_valid", PARAMS_W'(params_valid), 1);

    // degenerate quad
    xdeg = NOM_X; xdeg[9:0] = '0;
    drive(1, xdeg, NOM_Y, 0, 0);
    idle(LAT + 2);
    chk("deg_pulse", PARAMS_W'(degenerate), 1);
    drive(0, '0, '0, 1, 0);
    chk("deg_pulse_once", PARAMS_W'(degenerate), 0);
    chk("deg_p9_kept", PARAMS_W'(get_field(params, 8)), PARAMS_W'(nom_v[8]));
    chk("deg_valid_kept", PARAMS_W'(params_valid), 1);

    // back-to-back: A runs, B overwritten by C, C runs
    xa = rq_x(1); ya = $urandom; quad_b = rq_x(2); xc = rq_x(3); yc = $urandom;
    saw_b = 0; watch_b = 1;
    drive(1, xa, ya, 0, 0);
    idle(2);
    drive(1, quad_b, $urandom, 0, 0);
    drive(1, xc, yc, 0, 0);
    idle(3 * (LAT + 3));
    watch_b = 0;
    chk("b2b_b_never_driven", PARAMS_W'(saw_b), 0);
    chk("b2b_idle", PARAMS_W'(busy), 0);
    drive(0, '0, '0, 1, 0);
    chk("b2b_final_c", params, dp_func(xc, yc));

    // frame_start coincident with CAPTURE
    xd = rq_x(4); yd = $urandom;
    snap = dp_func(xc, yc);
    drive(1, xd, yd, 0, 0);
    idle(LAT + 1);
    drive(0, '0, '0, 1, 0);
    chk("coinc_no_swap", params, snap);
    idle(2);
    drive(0, '0, '0, 1, 0);
    chk("coinc_next_swap", params, dp_func(xd, yd));

    // reset during WAIT
    xe = rq_x(5); ye = $urandom;
    drive(1, xe, ye, 0, 0);
    idle(2);
    drive(0, '0, '0, 0, 1);
    chk("rstw_busy", PARAMS_W'(busy), 0);
    chk("rstw_params", params, '0);
    chk("rstw_valid", PARAMS_W'(params_valid), 0);
    idle(LAT + 4);
    drive(0, '0, '0, 1, 0);
    chk("rstw_no_publish", PARAMS_W'(params_valid), 0);

    // two captures before a frame boundary
    xf = rq_x(6); yf = $urandom; xg = rq_x(7); yg = $urandom;
    drive(1, xf, yf, 0, 0);
    idle(LAT + 3);
    drive(1, xg, yg, 0, 0);
    idle(LAT + 3);
    drive(0, '0, '0, 1, 0);
    chk("two_caps_latest", params, dp_func(xg, yg));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [CX_W-1:0] rx;
      rx = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rx[9:0] = '0;
      drive($urandom_range(0, 7) == 0, rx, CY_W'($urandom),
            $urandom_range(0, 15) == 0, $urandom_range(0, 499) == 0);
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
